// File: rtl/reset_seq_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reset_seq_pkg                                                   |
// | Brief    : State encoding and shared helpers for the board reset sequencer |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package reset_seq_pkg;

    localparam int unsigned c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_PLL_RST   = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_HOLD      = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_RELEASE   = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_RUN       = 3'd4;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_debounce.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_debounce                                                   |
// | Brief    : Multi-flop synchronizer with optional consecutive-sample filter |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sync_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign w_sample = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES <= 1) begin : g_sync_only
            // A single-sample filter would only add a flop of latency.
            assign o_level = w_sample;
        end else begin : g_debounce
            localparam int unsigned c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [c_CNT_W-1:0] r_cnt;
            logic               r_level;

            // r_cnt holds how many consecutive samples have disagreed with r_level.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (w_sample == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_level <= w_sample;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            assign o_level = r_level;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sys_reset_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sys_reset_sequencer                                             |
// | Brief    : PLL reset / lock wait, then ordered SOC and peripheral release  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sys_reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES  = 8,
    parameter int unsigned LOCK_TIMEOUT    = 100000,
    parameter int unsigned HOLD_CYCLES     = 1024,
    parameter int unsigned PER_DELAY       = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                 io_sys_clock,
    input  logic                 io_sys_reset,
    input  logic                 io_pll_locked,
    input  logic                 io_button_n,
    output logic                 io_pll_rst,
    output logic                 io_sys_reset_out,
    output logic                 io_per_reset_out,
    output logic [c_STATE_W-1:0] io_state,
    output logic [7:0]           io_lockLossCount
);

    localparam int unsigned c_CNT_MAX = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                             max2(HOLD_CYCLES, PER_DELAY));
    localparam int unsigned c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_SAT   = c_CNT_W'(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_PLL_LAST  = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PER_LAST  = c_CNT_W'(PER_DELAY - 1);

    logic                 w_lock;
    logic                 w_pressed;
    logic [c_STATE_W-1:0] r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_pll_rst;
    logic                 r_sys_rst;
    logic                 r_per_rst;
    logic [7:0]           r_loss_cnt;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_sync (
        .clk     (io_sys_clock),
        .rst     (io_sys_reset),
        .i_async (~io_button_n),
        .o_level (w_pressed)
    );

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (1)
    ) u_lock_sync (
        .clk     (io_sys_clock),
        .rst     (io_sys_reset),
        .i_async (io_pll_locked),
        .o_level (w_lock)
    );

    // Every transition clears r_cnt; otherwise it counts cycles spent in the state.
    always_ff @(posedge io_sys_clock) begin
        if (io_sys_reset) begin
            r_state    <= c_ST_PLL_RST;
            r_cnt      <= '0;
            r_pll_rst  <= 1'b1;
            r_sys_rst  <= 1'b1;
            r_per_rst  <= 1'b1;
            r_loss_cnt <= '0;
        end else begin
            if (r_cnt != c_CNT_SAT) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            case (r_state)
                c_ST_PLL_RST: begin
                    if (r_cnt == c_PLL_LAST) begin
                        r_state   <= c_ST_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end
                end
                c_ST_WAIT_LOCK: begin
                    if (w_lock) begin
                        r_state <= c_ST_HOLD;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_LOCK_LAST) begin
                        r_state   <= c_ST_PLL_RST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (!w_lock) begin
                        r_state <= c_ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (w_pressed) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        r_state   <= c_ST_RELEASE;
                        r_cnt     <= '0;
                        r_sys_rst <= 1'b0;
                    end
                end
                c_ST_RELEASE, c_ST_RUN: begin
                    // Lock loss outranks a button press when both arrive together.
                    if (!w_lock) begin
                        r_state   <= c_ST_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_sys_rst <= 1'b1;
                        r_per_rst <= 1'b1;
                        if (r_loss_cnt != 8'hFF) begin
                            r_loss_cnt <= r_loss_cnt + 8'd1;
                        end
                    end else if (w_pressed) begin
                        r_state   <= c_ST_HOLD;
                        r_cnt     <= '0;
                        r_sys_rst <= 1'b1;
                        r_per_rst <= 1'b1;
                    end else if (r_state == c_ST_RELEASE && r_cnt == c_PER_LAST) begin
                        r_state   <= c_ST_RUN;
                        r_cnt     <= '0;
                        r_per_rst <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_ST_PLL_RST;
                    r_cnt     <= '0;
                    r_pll_rst <= 1'b1;
                    r_sys_rst <= 1'b1;
                    r_per_rst <= 1'b1;
                end
            endcase
        end
    end

    assign io_pll_rst       = r_pll_rst;
    assign io_sys_reset_out = r_sys_rst;
    assign io_per_reset_out = r_per_rst;
    assign io_state         = r_state;
    assign io_lockLossCount = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sys_reset_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sys_reset_sequencer                                          |
// | Brief    : Vector table, corner sequences and random run vs. timing model  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sys_reset_sequencer;

    localparam int c_PLL  = 3;
    localparam int c_TO   = 20;
    localparam int c_HOLD = 8;
    localparam int c_PER  = 4;
    localparam int c_DEB  = 4;
    localparam int c_SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock_pin = 1'b0;
    logic       btn_n = 1'b1;
    logic       w_pll_rst, w_sys_rst, w_per_rst;
    logic [2:0] w_state;
    logic [7:0] w_llc;

    int n_tests = 0;
    int n_fail  = 0;

    sys_reset_sequencer #(
        .PLL_RST_CYCLES  (c_PLL),
        .LOCK_TIMEOUT    (c_TO),
        .HOLD_CYCLES     (c_HOLD),
        .PER_DELAY       (c_PER),
        .DEBOUNCE_CYCLES (c_DEB),
        .SYNC_STAGES     (c_SYNC)
    ) dut (
        .io_sys_clock     (clk),
        .io_sys_reset     (rst),
        .io_pll_locked    (lock_pin),
        .io_button_n      (btn_n),
        .io_pll_rst       (w_pll_rst),
        .io_sys_reset_out (w_sys_rst),
        .io_per_reset_out (w_per_rst),
        .io_state         (w_state),
        .io_lockLossCount (w_llc)
    );

    always #5 clk = ~clk;

    // Timing model: phases are tracked by the edge number on which they began,
    // and the pins are delayed / filtered with plain sample histories.
    int     m_ph;
    int     m_llc;
    longint m_n = 0;
    longint m_t_ent;
    longint m_t_hold;
    bit     m_pressed;
    bit     m_lk_q[$];
    bit     m_pb_q[$];
    bit     m_db_q[$];

    function automatic void m_reset();
        m_ph = 0; m_t_ent = m_n; m_t_hold = m_n; m_llc = 0; m_pressed = 1'b0;
        m_lk_q.delete(); m_pb_q.delete(); m_db_q.delete();
        for (int i = 0; i < c_SYNC; i++) begin
            m_lk_q.push_back(1'b0);
            m_pb_q.push_back(1'b0);
        end
        for (int i = 0; i < c_DEB; i++) m_db_q.push_back(1'b0);
    endfunction

    function automatic void m_enter(input int ph);
        m_ph = ph; m_t_ent = m_n; m_t_hold = m_n;
    endfunction

    function automatic void model_edge();
        bit ls, ps, all_new;
        m_n++;
        if (rst) begin
            m_reset();
            return;
        end
        ls = m_lk_q[c_SYNC-1];
        ps = m_pb_q[c_SYNC-1];
        case (m_ph)
            0: if (m_n - m_t_ent == c_PLL) m_enter(1);
            1: begin
                if (ls) m_enter(2);
                else if (m_n - m_t_ent == c_TO) m_enter(0);
            end
            2: begin
                if (!ls) m_enter(1);
                else if (m_pressed) m_t_hold = m_n;
                else if (m_n - m_t_hold == c_HOLD) m_enter(3);
            end
            default: begin
                if (!ls) begin
                    m_enter(1);
                    if (m_llc < 255) m_llc++;
                end else if (m_pressed) m_enter(2);
                else if (m_ph == 3 && m_n - m_t_ent == c_PER) m_enter(4);
            end
        endcase
        m_db_q.push_front(ps);
        void'(m_db_q.pop_back());
        all_new = 1'b1;
        foreach (m_db_q[i]) if (m_db_q[i] == m_pressed) all_new = 1'b0;
        if (all_new) m_pressed = ps;
        m_lk_q.push_front(lock_pin);
        void'(m_lk_q.pop_back());
        m_pb_q.push_front(!btn_n);
        void'(m_pb_q.pop_back());
    endfunction

    function automatic logic [13:0] mk(input int st, input bit pll, input bit sys,
                                       input bit per, input int llc);
        return {3'(st), pll, sys, per, 8'(llc)};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {w_state, w_pll_rst, w_sys_rst, w_per_rst, w_llc};
    endfunction

    function automatic logic [13:0] model_vec();
        return mk(m_ph, m_ph == 0, m_ph < 3, m_ph < 4, m_llc);
    endfunction

    task automatic check_vec(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got st=%0d pll=%b sys=%b per=%b llc=%0d, expected st=%0d pll=%b sys=%b per=%b llc=%0d",
                     name, $time, act[13:11], act[10], act[9], act[8], act[7:0],
                     exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_vec("model", dut_vec(), model_vec());
    endtask

    typedef struct {
        int         cycles;
        logic       rst;
        logic       lock;
        logic       btn_n;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int cyc, input bit r, input bit l, input bit b,
                                input logic [13:0] e);
        vec_t v;
        v.cycles = cyc; v.rst = r; v.lock = l; v.btn_n = b; v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();

        // Power-up, lock, release ordering, lock-loss recovery, button filtering,
        // simultaneous loss+press, and reset during RELEASE.
        add(2,  1, 0, 1, mk(0, 1, 1, 1, 0));
        add(2,  0, 0, 1, mk(0, 1, 1, 1, 0));
        add(1,  0, 0, 1, mk(1, 0, 1, 1, 0));
        add(2,  0, 1, 1, mk(1, 0, 1, 1, 0));
        add(1,  0, 1, 1, mk(2, 0, 1, 1, 0));
        add(7,  0, 1, 1, mk(2, 0, 1, 1, 0));
        add(1,  0, 1, 1, mk(3, 0, 0, 1, 0));
        add(3,  0, 1, 1, mk(3, 0, 0, 1, 0));
        add(1,  0, 1, 1, mk(4, 0, 0, 0, 0));
        add(5,  0, 1, 1, mk(4, 0, 0, 0, 0));
        add(2,  0, 0, 1, mk(4, 0, 0, 0, 0));
        add(1,  0, 1, 1, mk(1, 0, 1, 1, 1));
        add(1,  0, 1, 1, mk(1, 0, 1, 1, 1));
        add(1,  0, 1, 1, mk(2, 0, 1, 1, 1));
        add(7,  0, 1, 1, mk(2, 0, 1, 1, 1));
        add(1,  0, 1, 1, mk(3, 0, 0, 1, 1));
        add(3,  0, 1, 1, mk(3, 0, 0, 1, 1));
        add(1,  0, 1, 1, mk(4, 0, 0, 0, 1));
        add(3,  0, 1, 0, mk(4, 0, 0, 0, 1));
        add(6,  0, 1, 1, mk(4, 0, 0, 0, 1));
        add(6,  0, 1, 0, mk(4, 0, 0, 0, 1));
        add(1,  0, 1, 1, mk(2, 0, 1, 1, 1));
        add(12, 0, 1, 1, mk(2, 0, 1, 1, 1));
        add(1,  0, 1, 1, mk(3, 0, 0, 1, 1));
        add(4,  0, 1, 1, mk(4, 0, 0, 0, 1));
        add(4,  0, 1, 0, mk(4, 0, 0, 0, 1));
        add(2,  0, 0, 0, mk(4, 0, 0, 0, 1));
        add(1,  0, 0, 1, mk(1, 0, 1, 1, 2));
        add(2,  0, 1, 1, mk(1, 0, 1, 1, 2));
        add(1,  0, 1, 1, mk(2, 0, 1, 1, 2));
        add(9,  0, 1, 1, mk(2, 0, 1, 1, 2));
        add(1,  0, 1, 1, mk(3, 0, 0, 1, 2));
        add(2,  0, 1, 1, mk(3, 0, 0, 1, 2));
        add(1,  1, 1, 1, mk(0, 1, 1, 1, 0));
        add(2,  0, 1, 1, mk(0, 1, 1, 1, 0));
        add(1,  0, 1, 1, mk(1, 0, 1, 1, 0));
        add(1,  0, 1, 1, mk(2, 0, 1, 1, 0));

        foreach (vecs[k]) begin
            rst = vecs[k].rst; lock_pin = vecs[k].lock; btn_n = vecs[k].btn_n;
            for (int c = 0; c < vecs[k].cycles; c++) tick();
            check_vec($sformatf("vec%0d", k), dut_vec(), vecs[k].exp);
        end

        // Lock never arrives: 3-cycle PLL pulses repeating every 23 cycles.
        rst = 1'b1; lock_pin = 1'b0; btn_n = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 69; i++) begin
            if (i > 0) tick();
            check_val($sformatf("nolock_i%0d", i), int'({w_pll_rst, w_sys_rst, w_per_rst}),
                      int'({((i % 23) < 3), 2'b11}));
        end

        // Repeated lock losses from RELEASE: counter saturates at 255.
        lock_pin = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        check_val("sat_start_state", int'(w_state), 4);
        for (int it = 0; it < 300; it++) begin
            lock_pin = 1'b0;
            tick(); tick();
            lock_pin = 1'b1;
            for (int c = 0; c < 12; c++) tick();
            if (it == 99) check_val("llc_after_100", int'(w_llc), 100);
        end
        check_val("llc_saturated", int'(w_llc), 255);

        // Random pin activity, glitchy button, rare synchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) lock_pin = ~lock_pin;
            if ($urandom_range(0, 99) < 4) btn_n = ~btn_n;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
